// File: rtl/riscv_pcgen.sv
// Fetch-stage program-counter generator: holds the fetch PC, picks the next PC
// (sequential, branch redirect, trap/xRET redirect) and buffers a redirect that lands during a stall.
module riscv_pcgen #(
    parameter int unsigned XLEN         = 64,
    parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_8000_0000,
    parameter bit          C_EXT        = 1'b1
) (
    input  logic            i_riscv_pcgen_clk,
    input  logic            i_riscv_pcgen_rstn,
    input  logic            i_riscv_pcgen_stall,
    input  logic            i_riscv_pcgen_compressed,
    input  logic            i_riscv_pcgen_br_valid,
    input  logic [XLEN-1:0] i_riscv_pcgen_br_target,
    input  logic            i_riscv_pcgen_trap_valid,
    input  logic [XLEN-1:0] i_riscv_pcgen_trap_target,
    output logic [XLEN-1:0] o_riscv_pcgen_pc,
    output logic [XLEN-1:0] o_riscv_pcgen_pcplus,
    output logic            o_riscv_pcgen_pending,
    output logic            o_riscv_pcgen_misaligned
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        PEND_BR   = 2'd1,
        PEND_TRAP = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] RST_PC = RESET_VECTOR[XLEN-1:0];

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pend_tgt;
    logic            misaligned;

    logic [XLEN-1:0] step;
    logic [XLEN-1:0] trap_tgt;
    logic [XLEN-1:0] br_tgt;
    logic            br_bad;
    logic            br_ok;
    logic            trap;

    // Without the C extension a target with bit1 set can never be fetched, so the
    // branch is dropped here rather than redirecting fetch to an unreachable address.
    always_comb begin
        step     = (C_EXT && i_riscv_pcgen_compressed) ? XLEN'(2) : XLEN'(4);
        trap_tgt = {i_riscv_pcgen_trap_target[XLEN-1:2], 2'b00};
        br_tgt   = {i_riscv_pcgen_br_target[XLEN-1:1], 1'b0};
        br_bad   = !C_EXT && i_riscv_pcgen_br_target[1];
        br_ok    = i_riscv_pcgen_br_valid && !br_bad;
        trap     = i_riscv_pcgen_trap_valid;
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours; blocking here would create ordering races.
    always_ff @(posedge i_riscv_pcgen_clk or negedge i_riscv_pcgen_rstn) begin
        if (!i_riscv_pcgen_rstn) begin
            state      <= RUN;
            pc         <= RST_PC;
            pend_tgt   <= '0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= i_riscv_pcgen_br_valid && br_bad;
            case (state)
                RUN: begin
                    if (!i_riscv_pcgen_stall) begin
                        if (trap)       pc <= trap_tgt;
                        else if (br_ok) pc <= br_tgt;
                        else            pc <= o_riscv_pcgen_pcplus;
                    end else if (trap) begin
                        state    <= PEND_TRAP;
                        pend_tgt <= trap_tgt;
                    end else if (br_ok) begin
                        state    <= PEND_BR;
                        pend_tgt <= br_tgt;
                    end
                end
                PEND_BR: begin
                    if (!i_riscv_pcgen_stall) begin
                        if (trap)       pc <= trap_tgt;
                        else if (br_ok) pc <= br_tgt;
                        else            pc <= pend_tgt;
                        state <= RUN;
                    end else if (trap) begin
                        state    <= PEND_TRAP;
                        pend_tgt <= trap_tgt;
                    end else if (br_ok) begin
                        pend_tgt <= br_tgt;
                    end
                end
                PEND_TRAP: begin
                    // A buffered trap outranks any branch; only a newer trap replaces it.
                    if (!i_riscv_pcgen_stall) begin
                        pc    <= trap ? trap_tgt : pend_tgt;
                        state <= RUN;
                    end else if (trap) begin
                        pend_tgt <= trap_tgt;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign o_riscv_pcgen_pc         = pc;
    assign o_riscv_pcgen_pcplus     = pc + step;
    assign o_riscv_pcgen_pending    = (state != RUN);
    assign o_riscv_pcgen_misaligned = misaligned;

endmodule
